// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: on a CPU write to DMA_REG_ADDR, stalls the CPU and
// copies one 256-byte page into OAM_DATA_ADDR as 256 read/write pairs,
// with an extra alignment cycle when the trigger lands on an odd parity.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_R_nW,
    input  logic [7:0]  Data_bus_in,
    output logic [15:0] Addr_bus,
    output logic [7:0]  Data_bus_out,
    output logic        R_nW,
    output logic        cpu_rdy,
    output logic        dma_active
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t     state_q, state_d;
    logic       parity_q;
    logic [7:0] page_q;
    logic [7:0] index_q;
    logic [7:0] data_q;
    logic       trigger;

    // A DMA starts only on a CPU write to the DMA register while idle.
    assign trigger = (cpu_addr == DMA_REG_ADDR) && !cpu_R_nW;

    // Next-state and bus arbitration; CPU owns the bus only in IDLE.
    always_comb begin
        state_d      = state_q;
        Addr_bus     = cpu_addr;
        Data_bus_out = cpu_data_out;
        R_nW         = cpu_R_nW;
        cpu_rdy      = 1'b0;
        dma_active   = 1'b1;
        case (state_q)
            IDLE: begin
                cpu_rdy    = 1'b1;
                dma_active = 1'b0;
                if (trigger) state_d = HALT;
            end
            HALT: begin
                // Parity flips every clock, so the next cycle is even
                // exactly when the current parity is 1.
                R_nW    = 1'b1;
                state_d = parity_q ? READ : ALIGN;
            end
            ALIGN: begin
                R_nW    = 1'b1;
                state_d = READ;
            end
            READ: begin
                Addr_bus = {page_q, index_q};
                R_nW     = 1'b1;
                state_d  = WRITE;
            end
            WRITE: begin
                Addr_bus     = OAM_DATA_ADDR;
                Data_bus_out = data_q;
                R_nW         = 1'b0;
                state_d      = (index_q == 8'hFF) ? IDLE : READ;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, free-running parity, page/index counters and the data latch.
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            state_q  <= IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'h00;
            index_q  <= 8'h00;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            parity_q <= ~parity_q;
            if (state_q == IDLE && trigger) begin
                page_q  <= cpu_data_out;
                index_q <= 8'h00;
            end
            if (state_q == READ) data_q <= Data_bus_in;
            // Index wraps within the page; it never carries into page_q.
            if (state_q == WRITE) index_q <= index_q + 8'h01;
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: randomized CPU traffic against a cycle-indexed
// model of the DMA transfer derived from trigger parity and page.
module tb_oam_dma_ctrl;

    logic        clk_ph1 = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr = 16'h1234;
    logic [7:0]  cpu_data_out = 8'h00;
    logic        cpu_R_nW = 1'b1;
    logic [7:0]  Data_bus_in;
    logic [15:0] Addr_bus;
    logic [7:0]  Data_bus_out;
    logic        R_nW;
    logic        cpu_rdy;
    logic        dma_active;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [7:0]  key = 8'h5A;

    oam_dma_ctrl dut (
        .clk_ph1      (clk_ph1),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_R_nW     (cpu_R_nW),
        .Data_bus_in  (Data_bus_in),
        .Addr_bus     (Addr_bus),
        .Data_bus_out (Data_bus_out),
        .R_nW         (R_nW),
        .cpu_rdy      (cpu_rdy),
        .dma_active   (dma_active)
    );

    always #5 clk_ph1 = ~clk_ph1;

    // Memory model: byte at {pg,nn} is nn ^ key.
    assign Data_bus_in = Addr_bus[7:0] ^ key;

    // Cycles since reset; parity of the current cycle is cyc[0].
    always @(posedge clk_ph1) cyc <= rst ? cyc + 1 : 0;

    function automatic logic [31:0] mk(input logic [15:0] a, input logic rnw,
                                       input logic rdy, input logic act,
                                       input logic [7:0] d);
        return {5'b0, a, rnw, rdy, act, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // One idle CPU cycle: expect pure pass-through.
    task automatic idle_cycle(input string tag, input logic [15:0] a,
                              input logic [7:0] d, input logic rnw);
        @(negedge clk_ph1);
        cpu_addr = a; cpu_data_out = d; cpu_R_nW = rnw;
        #1;
        chk(tag, mk(Addr_bus, R_nW, cpu_rdy, dma_active, Data_bus_out),
            mk(a, rnw, 1'b1, 1'b0, d));
    endtask

    // Trigger a DMA of `page` on a cycle of parity want_par and check every
    // bus cycle; abort_read>0 pulls reset during that READ (1-based).
    task automatic run_dma(input logic [7:0] page, input int want_par, input int abort_read);
        bit          go;
        int          j, last;
        logic [31:0] exp, got;
        go = 0;
        for (int w = 0; w < 4 && !go; w++) begin
            @(negedge clk_ph1);
            if ((cyc & 1) == want_par) go = 1;
            else begin
                cpu_addr = 16'h0123; cpu_data_out = 8'h00; cpu_R_nW = 1'b1;
                #1;
                chk("pre", mk(Addr_bus, R_nW, cpu_rdy, dma_active, Data_bus_out),
                    mk(16'h0123, 1'b1, 1'b1, 1'b0, 8'h00));
            end
        end
        cpu_addr = 16'h4014; cpu_data_out = page; cpu_R_nW = 1'b0;
        #1;
        chk("trig", mk(Addr_bus, R_nW, cpu_rdy, dma_active, Data_bus_out),
            mk(16'h4014, 1'b0, 1'b1, 1'b0, page));
        last = 514 + want_par;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk_ph1);
            if (k == last) begin
                cpu_addr = 16'h0000; cpu_R_nW = 1'b1;
            end else begin
                cpu_addr = ($urandom_range(3) == 0) ? 16'h4014 : 16'($urandom);
                cpu_R_nW = 1'($urandom);
            end
            cpu_data_out = 8'($urandom);
            j = k - 2 - want_par;
            if (abort_read > 0 && j == 2 * (abort_read - 1)) rst = 1'b0;
            #1;
            if (k == last) begin
                exp = mk(cpu_addr, cpu_R_nW, 1'b1, 1'b0, cpu_data_out);
                got = mk(Addr_bus, R_nW, cpu_rdy, dma_active, Data_bus_out);
                chk("done", got, exp);
            end else if (j < 0) begin
                exp = mk(cpu_addr, 1'b1, 1'b0, 1'b1, 8'h00);
                got = mk(Addr_bus, R_nW, cpu_rdy, dma_active, 8'h00);
                chk("halt", got, exp);
            end else if (j % 2 == 0) begin
                exp = mk({page, 8'(j / 2)}, 1'b1, 1'b0, 1'b1, 8'h00);
                got = mk(Addr_bus, R_nW, cpu_rdy, dma_active, 8'h00);
                chk("read", got, exp);
            end else begin
                exp = mk(16'h2004, 1'b0, 1'b0, 1'b1, 8'(j / 2) ^ key);
                got = mk(Addr_bus, R_nW, cpu_rdy, dma_active, Data_bus_out);
                chk("write", got, exp);
            end
            if (!rst) begin
                @(negedge clk_ph1);
                rst = 1'b1;
                cpu_addr = 16'h1111; cpu_data_out = 8'h77; cpu_R_nW = 1'b1;
                #1;
                chk("abort", mk(Addr_bus, R_nW, cpu_rdy, dma_active, Data_bus_out),
                    mk(16'h1111, 1'b1, 1'b1, 1'b0, 8'h77));
                idle_cycle("abort_idle", 16'h2222, 8'h00, 1'b1);
                return;
            end
        end
    endtask

    initial begin
        // Reset held for two clocks with a CPU read on the bus.
        repeat (2) @(posedge clk_ph1);
        @(negedge clk_ph1);
        #1;
        chk("reset", mk(Addr_bus, R_nW, cpu_rdy, dma_active, 8'h00),
            mk(16'h1234, 1'b1, 1'b1, 1'b0, 8'h00));
        rst = 1'b1;

        // Non-triggering accesses.
        idle_cycle("rd4014", 16'h4014, 8'h02, 1'b1);
        idle_cycle("wr4015", 16'h4015, 8'h02, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if (a == 16'h4014) a = 16'h4013;
            idle_cycle("nontrig", a, 8'($urandom), 1'($urandom));
        end

        key = 8'h5A;
        run_dma(8'h02, 0, 0);
        run_dma(8'h02, 1, 0);
        key = 8'($urandom);
        run_dma(8'hFF, int'($urandom_range(1)), 0);
        run_dma(8'h00, int'($urandom_range(1)), 0);
        key = 8'h5A;
        run_dma(8'h02, int'($urandom_range(1)), 100);
        run_dma(8'h03, int'($urandom_range(1)), 0);
        key = 8'($urandom);
        run_dma(8'($urandom), int'($urandom_range(1)), int'($urandom_range(1, 256)));
        run_dma(8'($urandom), int'($urandom_range(1)), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 Parameter: DMA_REG_ADDR, default 16'h4014, CPU write address that triggers a DMA.
REQ-002 Parameter: OAM_DATA_ADDR, default 16'h2004, target address of every DMA write.
REQ-003 Port: clk_ph1  input  1  sole clock; all state updates on posedge clk_ph1.
REQ-004 Port: rst  input  1  reset; synchronous, active-low.
REQ-005 Port: cpu_addr  input  16  CPU address bus.
REQ-006 Port: cpu_data_out  input  8  CPU write data.
REQ-007 Port: cpu_R_nW  input  1  CPU read(1)/write(0).
REQ-008 Port: Data_bus_in  input  8  memory read data, valid in the cycle its address is driven.
REQ-009 Port: Addr_bus  output  16  arbitrated address to memory.
REQ-010 Port: Data_bus_out  output  8  arbitrated write data.
REQ-011 Port: R_nW  output  1  arbitrated read/write strobe.
REQ-012 Port: cpu_rdy  output  1  1 = CPU runs, 0 = CPU stalled.
REQ-013 Port: dma_active  output  1  1 while the controller owns the bus.

Function
REQ-014 States: IDLE, HALT, ALIGN, READ, WRITE; encoding is free.
REQ-015 A 1-bit parity register shall toggle every clock, free-running.
REQ-016 IDLE: Addr_bus/Data_bus_out/R_nW = cpu_addr/cpu_data_out/cpu_R_nW (combinational pass-through); cpu_rdy=1; dma_active=0.
REQ-017 IDLE -> HALT when, at a clock edge, cpu_addr==DMA_REG_ADDR and cpu_R_nW==0; page register <= cpu_data_out, index <= 0.
REQ-018 CPU reads of DMA_REG_ADDR and writes to any other address shall not trigger.
REQ-019 In every non-IDLE state: cpu_rdy=0, dma_active=1; CPU bus inputs ignored, including further writes to DMA_REG_ADDR.
REQ-020 HALT (one cycle): Addr_bus=cpu_addr, R_nW=1 (dummy read); next state READ if the next cycle's parity is 0, else ALIGN.
REQ-021 ALIGN (one cycle): Addr_bus=cpu_addr, R_nW=1; next state READ.
REQ-022 READ: Addr_bus={page,index}, R_nW=1; latch Data_bus_in into the data register at the edge; next state WRITE.
REQ-023 WRITE: Addr_bus=OAM_DATA_ADDR, R_nW=0, Data_bus_out = data register; index <= index+1 (8-bit, wraps 255->0).
REQ-024 WRITE -> READ if index was < 255; WRITE -> IDLE if index was 255.
REQ-025 Index increments never carry into the page; Addr_bus in READ stays within {page,8'h00}..{page,8'hFF}.
REQ-026 Total stall cycles (cpu_rdy=0) = 513 when the trigger cycle has parity 0, else 514; exactly 256 reads and 256 writes per DMA.
REQ-027 cpu_rdy returns to 1 in the cycle after the final WRITE, together with the pass-through bus.
REQ-028 The full 8-bit page value is honoured, including 8'h00 and 8'hFF.

Reset
REQ-029 rst==0 at an edge: state <= IDLE, parity <= 0, index <= 0, page <= 0, data register <= 0.
REQ-030 Outputs after reset: cpu_rdy=1, dma_active=0, bus in pass-through.
REQ-031 Reset mid-DMA: abort immediately, no further DMA cycles, no resumption after rst returns to 1.

Verification
REQ-032 Hold rst=0 for 2 clocks with cpu_addr=16'h1234, cpu_R_nW=1 -> cpu_rdy=1, dma_active=0, Addr_bus=16'h1234, R_nW=1.
REQ-033 Write 8'h02 to 16'h4014 on a parity-0 cycle T; memory[16'h02nn]=nn^8'h5A -> READ 16'h0200 at T+2; 256 writes to 16'h2004 carrying 8'h5A,8'h5B,...,8'hA5 in order; last WRITE at T+513; cpu_rdy=1 at T+514.
REQ-034 Same trigger on a parity-1 cycle -> ALIGN at T+2, first READ at T+3, cpu_rdy=1 at T+515 (514 stall cycles).
REQ-035 Trigger with page 8'hFF -> reads 16'hFF00..16'hFFFF, never 16'h0000; the controller returns to IDLE after the 256th write.
REQ-036 Assert rst=0 during the 100th READ -> next cycle cpu_rdy=1, pass-through bus; a new write of 8'h03 restarts at 16'h0300, index 0.
REQ-037 CPU reads 16'h4014, then writes 16'h4015 -> cpu_rdy stays 1 and dma_active stays 0 throughout.
